mem_apb_arbiter: RTL

Shares the core's single unified memory port between two requesters, the multicycle core (port 0) and a DMA engine (port 1), and drives it as an APB master. It arbitrates round-robin, sequences each transfer through APB SETUP/ACCESS phases with slave wait states, bounds stalls with a timeout, and returns a one-cycle completion pulse with read data and error status to the winning requester.

---
 rtl/mem_arb_pkg.sv | 7 +
 rtl/mem_apb_arbiter_rr_arb2.sv | 21 ++
 rtl/mem_apb_arbiter.sv | 114 +++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the APB memory-port arbiter
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_DMA = 1'b1;
    localparam int TIMEOUT_DEFAULT = 16;
endpackage

// File: rtl/mem_apb_arbiter_rr_arb2.sv
// rr_arb2: two-requester round-robin picker producing a one-hot grant
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] grant
);
    logic last_grant;
    // on a tie the port that did not win last time is chosen
    always_comb begin
        grant = !en ? 2'b00 : (req == 2'b11) ? (last_grant ? 2'b01 : 2'b10) : req;
    end
    // remember the most recent winner; starts at DMA so the core wins the first tie
    always_ff @(posedge clk) begin
        if (!reset) last_grant <= PORT_DMA;
        else if (|grant) last_grant <= grant[1];
    end
endmodule

// File: rtl/mem_apb_arbiter.sv
// mem_apb_arbiter: shares one APB memory port between the core and a DMA engine
module mem_apb_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req0_valid,
    input  logic                req0_write,
    input  logic [ADDR_W-1:0]   req0_addr,
    input  logic [DATA_W-1:0]   req0_wdata,
    input  logic [DATA_W/8-1:0] req0_wstrb,
    output logic                req0_ready,
    output logic [DATA_W-1:0]   req0_rdata,
    output logic                req0_err,
    input  logic                req1_valid,
    input  logic                req1_write,
    input  logic [ADDR_W-1:0]   req1_addr,
    input  logic [DATA_W-1:0]   req1_wdata,
    input  logic [DATA_W/8-1:0] req1_wstrb,
    output logic                req1_ready,
    output logic [DATA_W-1:0]   req1_rdata,
    output logic                req1_err,
    output logic [ADDR_W-1:0]   paddr,
    output logic                psel,
    output logic                penable,
    output logic                pwrite,
    output logic [DATA_W-1:0]   pwdata,
    output logic [DATA_W/8-1:0] pstrb,
    input  logic [DATA_W-1:0]   prdata,
    input  logic                pready,
    input  logic                pslverr
);
    localparam int CW = $clog2(TIMEOUT + 1);
    state_t state, next_state;
    logic [CW-1:0] wait_cnt;
    logic [1:0] grant;
    logic gnt;
    logic arb_en;
    logic timed_out;
    logic done;
    logic err_c;
    logic [DATA_W-1:0] rdata_c;

    assign arb_en = (state == IDLE);

    rr_arb2 u_arb (
        .clk(clk),
        .reset(reset),
        .en(arb_en),
        .req({req1_valid, req0_valid}),
        .grant(grant)
    );

    // state register
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else state <= next_state;
    end

    // next-state: one pass IDLE -> SETUP -> ACCESS (waits) -> IDLE per transfer
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    next_state = (req0_valid || req1_valid) ? SETUP : IDLE;
            SETUP:   next_state = ACCESS;
            ACCESS:  next_state = done ? IDLE : ACCESS;
            default: next_state = IDLE;
        endcase
    end

    // APB strobes and completion; a timeout completes with an error and no data
    always_comb begin
        psel = (state != IDLE);
        penable = (state == ACCESS);
        timed_out = (wait_cnt == CW'(TIMEOUT - 1));
        done = (state == ACCESS) && (pready || timed_out);
        err_c = pready ? pslverr : 1'b1;
        rdata_c = (pready && !pwrite) ? prdata : '0;
        req0_ready = done && (gnt == PORT_CORE);
        req1_ready = done && (gnt == PORT_DMA);
        req0_rdata = req0_ready ? rdata_c : '0;
        req1_rdata = req1_ready ? rdata_c : '0;
        req0_err = req0_ready && err_c;
        req1_err = req1_ready && err_c;
    end

    // capture the winner's request so the APB fields stay stable for the whole transfer
    always_ff @(posedge clk) begin
        if (!reset) begin
            gnt <= PORT_CORE;
            pwrite <= 1'b0;
            paddr <= '0;
            pwdata <= '0;
            pstrb <= '0;
        end else if (|grant) begin
            gnt <= grant[1];
            pwrite <= grant[1] ? req1_write : req0_write;
            paddr <= grant[1] ? req1_addr : req0_addr;
            pwdata <= grant[1] ? req1_wdata : req0_wdata;
            pstrb <= grant[1] ? req1_wstrb : req0_wstrb;
        end
    end

    // count ACCESS cycles without pready; restarts for each new transfer
    always_ff @(posedge clk) begin
        if (!reset) wait_cnt <= '0;
        else if (next_state == SETUP) wait_cnt <= '0;
        else if (state == ACCESS && !pready) wait_cnt <= wait_cnt + 1'b1;
    end
endmodule
